// File: rtl/rf_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the register-file write arbiter slice:
//   RF_AW / RF_DW / RF_DEPTH : register file geometry
//   arb_state_t              : arbiter state (ARB = free round-robin,
//                              LOCKED = port reserved for one owner)
//   idx_w()                  : width of an index into n requesters (min 1)
// Configuration macro used by this slice: RF_WR_BYPASS_EN (see top).
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int RF_AW    = 5;
    localparam int RF_DW    = 32;
    localparam int RF_DEPTH = 32;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // A single requester still needs a 1-bit index so vectors stay legal.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter_if
// Bundles the requester handshake and the register-file write port.
//   REQ_VALID/REQ_LOCK  per-requester request and lock-after-this-beat
//   REQ_ADDR/REQ_DATA   packed per-requester address/data (slice i = [W*i +: W])
//   REQ_READY           one-hot (or zero) acceptance
//   WE3/RA3/WD3         registered register-file write port
//   OWNER/LOCKED        current lock owner and lock state
// Modports: master = writeback sources side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface rf_write_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = rf_pkg::RF_AW,
    parameter int DW   = rf_pkg::RF_DW
);
    localparam int OW = rf_pkg::idx_w(NREQ);

    logic [NREQ-1:0]    REQ_VALID;
    logic [NREQ-1:0]    REQ_LOCK;
    logic [AW*NREQ-1:0] REQ_ADDR;
    logic [DW*NREQ-1:0] REQ_DATA;
    logic [NREQ-1:0]    REQ_READY;
    logic               WE3;
    logic [AW-1:0]      RA3;
    logic [DW-1:0]      WD3;
    logic [OW-1:0]      OWNER;
    logic               LOCKED;

    modport master (
        output REQ_VALID, REQ_LOCK, REQ_ADDR, REQ_DATA,
        input  REQ_READY, WE3, RA3, WD3, OWNER, LOCKED
    );

    modport slave (
        input  REQ_VALID, REQ_LOCK, REQ_ADDR, REQ_DATA,
        output REQ_READY, WE3, RA3, WD3, OWNER, LOCKED
    );

endinterface

// File: rtl/rf_write_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rf_rr_pick
// Combinational round-robin picker: selects the first set bit of i_valid
// searching i_ptr, i_ptr+1, ... modulo NREQ.
//   i_valid : candidate vector
//   i_ptr   : highest-priority index this cycle
//   o_grant : one-hot grant (zero when nothing is valid)
//   o_idx   : index of the granted bit
//   o_any   : at least one candidate was valid
// ---------------------------------------------------------------------------
module rf_rr_pick
    import rf_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         i_valid,
    input  logic [idx_w(NREQ)-1:0]  i_ptr,
    output logic [NREQ-1:0]         o_grant,
    output logic [idx_w(NREQ)-1:0]  o_idx,
    output logic                    o_any
);
    localparam int IW = idx_w(NREQ);

    // Walk the offsets from farthest to nearest so the nearest valid
    // requester to the pointer overwrites any earlier match.
    always_comb begin
        logic [IW-1:0] j;
        j       = '0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = IW'((int'(i_ptr) + k) % NREQ);
            if (i_valid[j]) begin
                o_grant    = '0;
                o_grant[j] = 1'b1;
                o_idx      = j;
                o_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
// Shares the register file's single write port between NREQ writeback
// sources using round-robin grants with an optional multi-beat lock.
// Accepted beats are registered onto WE3/RA3/WD3 one CLK edge later.
//   CLK, RST_N : clock (rising edge), asynchronous active-low reset
//   STALL      : global hold, no grants while high
//   bus        : rf_write_arbiter_if.slave (requests, ready, write port,
//                OWNER, LOCKED)
// Optional feature, macro RF_WR_BYPASS_EN:
//   BYP_RA in, BYP_HIT/BYP_DATA out -- combinational forward of the write
//   that commits at the next edge.
// ---------------------------------------------------------------------------
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = RF_AW,
    parameter int DW   = RF_DW
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                STALL,
`ifdef RF_WR_BYPASS_EN
    input  logic [AW-1:0]       BYP_RA,
    output logic                BYP_HIT,
    output logic [DW-1:0]       BYP_DATA,
`endif
    rf_write_arbiter_if.slave   bus
);
    localparam int IW = idx_w(NREQ);

    arb_state_t       r_state;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_owner;
    logic             r_we;
    logic [AW-1:0]    r_ra;
    logic [DW-1:0]    r_wd;

    logic [NREQ-1:0]  w_eligible;
    logic [NREQ-1:0]  w_grant;
    logic [NREQ-1:0]  w_ready;
    logic [IW-1:0]    w_idx;
    logic [IW-1:0]    w_ptr_next;
    logic             w_any;
    logic             w_accept;
    logic             w_lock;
    logic [AW-1:0]    w_addr;
    logic [DW-1:0]    w_data;

    // While locked only the owner may compete; everyone else is masked.
    always_comb begin
        w_eligible = bus.REQ_VALID;
        if (r_state == LOCKED) begin
            w_eligible          = '0;
            w_eligible[r_owner] = bus.REQ_VALID[r_owner];
        end
    end

    rf_rr_pick #(.NREQ(NREQ)) u_pick (
        .i_valid (w_eligible),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Reset gating keeps READY low during the asynchronous reset window.
    assign w_ready  = (RST_N && !STALL && w_any) ? w_grant : '0;
    assign w_accept = |w_ready;

    always_comb begin
        w_addr = '0;
        w_data = '0;
        w_lock = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_idx == IW'(i)) begin
                w_addr = bus.REQ_ADDR[AW*i +: AW];
                w_data = bus.REQ_DATA[DW*i +: DW];
                w_lock = bus.REQ_LOCK[i];
            end
        end
    end

    assign w_ptr_next = (int'(w_idx) == NREQ - 1) ? '0 : w_idx + 1'b1;

    // Arbiter FSM and write stage. A beat to address 0 is consumed but
    // treated as no write at all, so RA3/WD3 keep the last real write.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ARB;
            r_ptr   <= '0;
            r_owner <= '0;
            r_we    <= 1'b0;
            r_ra    <= '0;
            r_wd    <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_accept) begin
                r_ptr <= w_ptr_next;
                if (w_addr != '0) begin
                    r_we <= 1'b1;
                    r_ra <= w_addr;
                    r_wd <= w_data;
                end
                case (r_state)
                    ARB: begin
                        if (w_lock) begin
                            r_state <= LOCKED;
                            r_owner <= w_idx;
                        end
                    end
                    LOCKED: begin
                        if (!w_lock) begin
                            r_state <= ARB;
                        end
                    end
                    default: r_state <= ARB;
                endcase
            end
        end
    end

    assign bus.REQ_READY = w_ready;
    assign bus.WE3       = r_we;
    assign bus.RA3       = r_ra;
    assign bus.WD3       = r_wd;
    assign bus.OWNER     = r_owner;
    assign bus.LOCKED    = (r_state == LOCKED);

`ifdef RF_WR_BYPASS_EN
    assign BYP_HIT  = r_we && (r_ra == BYP_RA) && (BYP_RA != '0);
    assign BYP_DATA = r_wd;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_write_arbiter
// Scoreboard bench for rf_write_arbiter with two requesters. Each test task
// drives one beat per cycle, checks REQ_READY/LOCKED/OWNER inline and pushes
// the expected write-port contents; the monitor pops one entry per edge.
// Bypass checks are built when RF_WR_BYPASS_EN is defined.
// ---------------------------------------------------------------------------
module tb_rf_write_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 5;
    localparam int DW   = 32;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] ra;
        logic [DW-1:0] wd;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic stall = 1'b0;

    rf_write_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

`ifdef RF_WR_BYPASS_EN
    logic [AW-1:0] bypRa = '0;
    logic          bypHit;
    logic [DW-1:0] bypData;
`endif

    rf_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .STALL    (stall),
`ifdef RF_WR_BYPASS_EN
        .BYP_RA   (bypRa),
        .BYP_HIT  (bypHit),
        .BYP_DATA (bypData),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    wr_t           sb[$];
    wr_t           mon;
    logic [AW-1:0] lastRa = '0;
    logic [DW-1:0] lastWd = '0;
    int            nChecks = 0;
    int            nFail   = 0;

    // Write-port monitor: one scoreboard entry is consumed per clock edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon = sb.pop_front();
            nChecks++;
            if ({bus.WE3, bus.RA3, bus.WD3} !== mon) begin
                nFail++;
                $display("[TB] FAIL write_port: got we=%0b ra=%0d wd=%h, want we=%0b ra=%0d wd=%h",
                         bus.WE3, bus.RA3, bus.WD3, mon.we, mon.ra, mon.wd);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] v, input logic [1:0] l,
                                 input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                 input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        bus.REQ_VALID = v;
        bus.REQ_LOCK  = l;
        bus.REQ_ADDR  = {a1, a0};
        bus.REQ_DATA  = {d1, d0};
    endtask

    // Expected write-port state after the coming edge; who < 0 means idle.
    task automatic expectWrite(input int who);
        wr_t           x;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        a = (who == 1) ? bus.REQ_ADDR[2*AW-1:AW] : bus.REQ_ADDR[AW-1:0];
        d = (who == 1) ? bus.REQ_DATA[2*DW-1:DW] : bus.REQ_DATA[DW-1:0];
        x.we = 1'b0;
        if (who >= 0 && a != '0) begin
            x.we   = 1'b1;
            lastRa = a;
            lastWd = d;
        end
        x.ra = lastRa;
        x.wd = lastWd;
        sb.push_back(x);
    endtask

    task automatic test_reset();
        applyStimulus(2'b01, 2'b00, 5'd5, 32'h1, 5'd0, 32'h0);
        #1 rst_n = 1'b0;
        #1;
        nChecks++;
        if (bus.REQ_READY !== 2'b00) begin
            nFail++;
            $display("[TB] FAIL reset_ready: got %b want 00", bus.REQ_READY);
        end
        nChecks++;
        if ({bus.WE3, bus.RA3, bus.WD3, bus.LOCKED, bus.OWNER} !== '0) begin
            nFail++;
            $display("[TB] FAIL reset_state: got we=%0b ra=%0d wd=%h locked=%0b owner=%0d, want all 0",
                     bus.WE3, bus.RA3, bus.WD3, bus.LOCKED, bus.OWNER);
        end
        applyStimulus(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        applyStimulus(2'b01, 2'b00, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
        #1;
        nChecks++;
        if (bus.REQ_READY !== 2'b01) begin
            nFail++;
            $display("[TB] FAIL single_ready: got %b want 01", bus.REQ_READY);
        end
        expectWrite(0);
        tick();
        applyStimulus(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        expectWrite(-1);
        tick();
    endtask

    // Pointer sits at 1 after the single write, so req1 wins first.
    task automatic test_round_robin();
        logic [1:0] expG;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2'b11, 2'b00, 5'd1, 32'h11111111, 5'd2, 32'h22222222);
            #1;
            expG = (k % 2 == 0) ? 2'b10 : 2'b01;
            nChecks++;
            if (bus.REQ_READY !== expG) begin
                nFail++;
                $display("[TB] FAIL rr_grant%0d: got %b want %b", k, bus.REQ_READY, expG);
            end
            expectWrite((expG == 2'b10) ? 1 : 0);
            tick();
        end
        applyStimulus(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        expectWrite(-1);
        tick();
    endtask

    task automatic test_zero_addr();
        applyStimulus(2'b10, 2'b00, 5'd0, 32'h0, 5'd0, 32'h1234);
        #1;
        nChecks++;
        if (bus.REQ_READY !== 2'b10) begin
            nFail++;
            $display("[TB] FAIL zero_ready: got %b want 10", bus.REQ_READY);
        end
        expectWrite(1);
        tick();
        applyStimulus(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        expectWrite(-1);
        tick();
    endtask

    // Pointer is 0 here; one req0 beat moves it to 1 so req1 opens the burst.
    task automatic test_lock();
        applyStimulus(2'b01, 2'b00, 5'd3, 32'h30, 5'd0, 32'h0);
        #1;
        expectWrite(0);
        tick();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'b11, {(k < 2), 1'b0}, 5'd3, 32'h33, 5'(4 + k), 32'h40 + k);
            #1;
            nChecks++;
            if (bus.REQ_READY !== 2'b10) begin
                nFail++;
                $display("[TB] FAIL lock_grant%0d: got %b want 10", k, bus.REQ_READY);
            end
            expectWrite(1);
            tick();
            nChecks++;
            if (bus.LOCKED !== (k < 2) || (k < 2 && bus.OWNER !== 1'b1)) begin
                nFail++;
                $display("[TB] FAIL lock_state%0d: got locked=%0b owner=%0d want locked=%0b owner=1",
                         k, bus.LOCKED, bus.OWNER, (k < 2));
            end
        end
        applyStimulus(2'b01, 2'b00, 5'd3, 32'h33, 5'd0, 32'h0);
        #1;
        nChecks++;
        if (bus.REQ_READY !== 2'b01) begin
            nFail++;
            $display("[TB] FAIL lock_release: got %b want 01", bus.REQ_READY);
        end
        expectWrite(0);
        tick();
        applyStimulus(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        expectWrite(-1);
        tick();
    endtask

    task automatic test_stall();
        applyStimulus(2'b10, 2'b10, 5'd0, 32'h0, 5'd8, 32'h80);
        #1;
        expectWrite(1);
        tick();
        stall = 1'b1;
        applyStimulus(2'b11, 2'b00, 5'd1, 32'h01, 5'd9, 32'h90);
        for (int k = 0; k < 2; k++) begin
            #1;
            nChecks++;
            if (bus.REQ_READY !== 2'b00) begin
                nFail++;
                $display("[TB] FAIL stall_ready%0d: got %b want 00", k, bus.REQ_READY);
            end
            expectWrite(-1);
            tick();
            nChecks++;
            if (bus.LOCKED !== 1'b1 || bus.OWNER !== 1'b1) begin
                nFail++;
                $display("[TB] FAIL stall_lock%0d: got locked=%0b owner=%0d want locked=1 owner=1",
                         k, bus.LOCKED, bus.OWNER);
            end
        end
        stall = 1'b0;
        #1;
        nChecks++;
        if (bus.REQ_READY !== 2'b10) begin
            nFail++;
            $display("[TB] FAIL stall_owner: got %b want 10", bus.REQ_READY);
        end
        expectWrite(1);
        tick();
        applyStimulus(2'b01, 2'b00, 5'd1, 32'h01, 5'd0, 32'h0);
        #1;
        nChecks++;
        if (bus.REQ_READY !== 2'b01 || bus.LOCKED !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL stall_after: got ready=%b locked=%0b want ready=01 locked=0",
                     bus.REQ_READY, bus.LOCKED);
        end
        expectWrite(0);
        tick();
        applyStimulus(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        expectWrite(-1);
        tick();
    endtask

    task automatic test_async_reset();
        applyStimulus(2'b10, 2'b10, 5'd0, 32'h0, 5'd12, 32'hC0);
        #1;
        expectWrite(1);
        tick();
        applyStimulus(2'b11, 2'b10, 5'd1, 32'h01, 5'd13, 32'hC1);
        #1;
        expectWrite(1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        nChecks++;
        if ({bus.WE3, bus.LOCKED, bus.REQ_READY, bus.RA3, bus.WD3} !== '0) begin
            nFail++;
            $display("[TB] FAIL async_reset: got we=%0b locked=%0b ready=%b ra=%0d wd=%h, want all 0",
                     bus.WE3, bus.LOCKED, bus.REQ_READY, bus.RA3, bus.WD3);
        end
        sb.delete();
        lastRa = '0;
        lastWd = '0;
        applyStimulus(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        applyStimulus(2'b11, 2'b00, 5'd2, 32'h5A5A0000, 5'd3, 32'h5A5A0001);
        #1;
        nChecks++;
        if (bus.REQ_READY !== 2'b01) begin
            nFail++;
            $display("[TB] FAIL reset_unlock: got %b want 01", bus.REQ_READY);
        end
        expectWrite(0);
        tick();
        applyStimulus(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        expectWrite(-1);
        tick();
    endtask

    task automatic test_back_to_back();
        applyStimulus(2'b01, 2'b00, 5'd20, 32'hAAAA0001, 5'd0, 32'h0);
        #1;
        expectWrite(0);
        tick();
        applyStimulus(2'b01, 2'b00, 5'd20, 32'hAAAA0002, 5'd0, 32'h0);
        #1;
        nChecks++;
        if (bus.REQ_READY !== 2'b01) begin
            nFail++;
            $display("[TB] FAIL b2b_ready: got %b want 01", bus.REQ_READY);
        end
        expectWrite(0);
        tick();
        applyStimulus(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        expectWrite(-1);
        tick();
        nChecks++;
        if (bus.WD3 !== 32'hAAAA0002) begin
            nFail++;
            $display("[TB] FAIL b2b_last: got %h want aaaa0002", bus.WD3);
        end
    endtask

`ifdef RF_WR_BYPASS_EN
    task automatic test_bypass();
        applyStimulus(2'b01, 2'b00, 5'd7, 32'hA5A5A5A5, 5'd0, 32'h0);
        bypRa = 5'd7;
        #1;
        expectWrite(0);
        tick();
        nChecks++;
        if (bypHit !== 1'b1 || bypData !== 32'hA5A5A5A5) begin
            nFail++;
            $display("[TB] FAIL byp_hit: got hit=%0b data=%h want hit=1 data=a5a5a5a5", bypHit, bypData);
        end
        bypRa = 5'd0;
        #1;
        nChecks++;
        if (bypHit !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL byp_zero: got hit=%0b want 0", bypHit);
        end
        applyStimulus(2'b00, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        bypRa = 5'd7;
        expectWrite(-1);
        tick();
        nChecks++;
        if (bypHit !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL byp_idle: got hit=%0b want 0", bypHit);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_zero_addr();
        test_lock();
        test_stall();
        test_async_reset();
        test_back_to_back();
`ifdef RF_WR_BYPASS_EN
        test_bypass();
`endif
        tick();
        nChecks++;
        if (sb.size() != 0) begin
            nFail++;
            $display("[TB] FAIL sb_drain: got %0d pending want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
